// File: rtl/imem_dumper_pkg.sv
// Shared definitions for the instruction-memory dump/load blocks:
// FSM state encoding, word geometry and byte extraction.
package imem_dumper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_DONE  = 2'd3
  } dump_state_t;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

  // Little-endian byte lane select: lane 0 is bits 7:0.
  function automatic logic [7:0] word_byte(input logic [31:0]           word,
                                           input logic [BYTE_IDX_W-1:0] idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/imem_dumper_word_serializer.sv
// Turns one loaded 32-bit word into a little-endian valid/ready byte stream,
// flagging the final byte when the loaded word is the last of the dump.
module word_serializer
  import imem_dumper_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] word,
  input  logic        last_word,
  input  logic        ready,
  output logic        valid,
  output logic [7:0]  data,
  output logic        last_byte,
  output logic        word_taken
);

  localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(BYTES_PER_WORD - 1);

  logic [31:0]           word_q;
  logic [BYTE_IDX_W-1:0] byte_idx;
  logic [BYTE_IDX_W-1:0] next_idx;
  logic                  last_word_q;

  assign next_idx   = byte_idx + 1'b1;
  assign word_taken = valid && ready && (byte_idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (reset) begin
      word_q      <= '0;
      byte_idx    <= '0;
      last_word_q <= 1'b0;
      valid       <= 1'b0;
      data        <= '0;
      last_byte   <= 1'b0;
    end else if (load) begin
      word_q      <= word;
      byte_idx    <= '0;
      last_word_q <= last_word;
      valid       <= 1'b1;
      data        <= word_byte(word, '0);
      last_byte   <= last_word && (LAST_IDX == '0);
    end else if (valid && ready) begin
      if (byte_idx == LAST_IDX) begin
        valid     <= 1'b0;
        last_byte <= 1'b0;
      end else begin
        // data/last are registered, so the next lane is selected one step ahead
        byte_idx  <= next_idx;
        data      <= word_byte(word_q, next_idx);
        last_byte <= last_word_q && (next_idx == LAST_IDX);
      end
    end
  end

endmodule

// File: rtl/imem_dumper.sv
// Read-back engine: walks WORD_COUNT words of instrMem through its test port,
// streams them out as bytes and accumulates a 32-bit wrapping checksum.
module imem_dumper
  import imem_dumper_pkg::*;
#(
  parameter int unsigned WORD_COUNT = 256,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] test_addr,
  input  logic [31:0] test_data_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic [31:0] checksum
);

  localparam int unsigned         IDX_W     = $clog2(WORD_COUNT) + 1;
  localparam logic [IDX_W-1:0]    LAST_WORD = IDX_W'(WORD_COUNT - 1);

  dump_state_t      state;
  logic [IDX_W-1:0] word_idx;
  logic             is_last_word;
  logic             load;
  logic             word_taken;

  assign is_last_word = (word_idx == LAST_WORD);
  assign load         = (state == ST_FETCH);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      word_idx  <= '0;
      test_addr <= BASE_ADDR;
      checksum  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            checksum  <= '0;
            word_idx  <= '0;
            test_addr <= BASE_ADDR;
            busy      <= 1'b1;
            state     <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          checksum <= checksum + test_data_out;
          state    <= ST_SEND;
        end
        ST_SEND: begin
          if (word_taken) begin
            if (is_last_word) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              // test_addr tracks BASE_ADDR + word_idx and moves only on entry to FETCH
              word_idx  <= word_idx + 1'b1;
              test_addr <= test_addr + 32'd1;
              state     <= ST_FETCH;
            end
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  word_serializer u_serializer (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .word       (test_data_out),
    .last_word  (is_last_word),
    .ready      (out_ready),
    .valid      (out_valid),
    .data       (out_data),
    .last_byte  (out_last),
    .word_taken (word_taken)
  );

endmodule
